// File: rtl/clock_24_hour_structural_pkg.sv
// Shared constants for the BCD time-of-day counter: digit field layout,
// per-digit wrap limits and the cleared time value.
package clock_24_hour_structural_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 6 * DIGIT_W;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Bit offsets of each digit inside the packed HH:MM:SS word
  localparam int SEC_O  = 0;
  localparam int SEC_T  = 4;
  localparam int MIN_O  = 8;
  localparam int MIN_T  = 12;
  localparam int HOUR_O = 16;
  localparam int HOUR_T = 20;

  localparam bcd_digit_t SEC_O_MAX  = 4'd9;
  localparam bcd_digit_t SEC_T_MAX  = 4'd5;
  localparam bcd_digit_t MIN_O_MAX  = 4'd9;
  localparam bcd_digit_t MIN_T_MAX  = 4'd5;
  localparam bcd_digit_t HOUR_O_MAX = 4'd9;
  localparam bcd_digit_t HOUR_T_MAX = 4'd2;

  // Last hour of the day is 23; anything at or past it rolls to 00
  localparam bcd_digit_t HOUR_WRAP_T = 4'd2;
  localparam bcd_digit_t HOUR_WRAP_O = 4'd3;

  localparam logic [TIME_W-1:0] TIME_RESET  = 24'h000000;
  localparam bcd_digit_t        DIGIT_RESET = TIME_RESET[DIGIT_W-1:0];

endpackage

// File: rtl/clock_24_hour_structural_digit.sv
// One BCD digit: synchronous clear, parallel load, and increment that wraps
// to zero once the digit is at or above MAX, raising carry in that cycle.
module bcd_digit_counter
  import clock_24_hour_structural_pkg::*;
#(
  parameter bcd_digit_t MAX = 4'd9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;
  logic       at_max;

  // ">=" so that out-of-range loaded digits snap back to zero
  assign at_max = (q_q >= MAX);
  assign carry  = inc && at_max;
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = at_max ? DIGIT_RESET : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= DIGIT_RESET;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/clock_24_hour_structural.sv
// 24-hour HH:MM:SS counter built from a ripple chain of BCD digit counters;
// the hour pair gets an extra override that folds 23 (and above) back to 00.
module clock_24_hour_structural
  import clock_24_hour_structural_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset_time,
  input  logic              Set_time,
  input  logic [TIME_W-1:0] Time_in,
  output logic [TIME_W-1:0] Time_out
);

  bcd_digit_t sec_o_q, sec_t_q, min_o_q, min_t_q, hour_o_q, hour_t_q;
  logic       sec_o_c, sec_t_c, min_o_c, min_t_c, hour_o_c, hour_t_c;
  logic       hour_override;
  logic       hour_wrap;
  logic       hour_load;
  bcd_digit_t hour_o_load_val;
  bcd_digit_t hour_t_load_val;

  bcd_digit_counter #(.MAX(SEC_O_MAX)) u_sec_o (
    .clk(CLK), .rst_n(Reset_time), .load(Set_time),
    .load_val(Time_in[SEC_O +: DIGIT_W]), .inc(1'b1),
    .q(sec_o_q), .carry(sec_o_c)
  );

  bcd_digit_counter #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(CLK), .rst_n(Reset_time), .load(Set_time),
    .load_val(Time_in[SEC_T +: DIGIT_W]), .inc(sec_o_c),
    .q(sec_t_q), .carry(sec_t_c)
  );

  bcd_digit_counter #(.MAX(MIN_O_MAX)) u_min_o (
    .clk(CLK), .rst_n(Reset_time), .load(Set_time),
    .load_val(Time_in[MIN_O +: DIGIT_W]), .inc(sec_t_c),
    .q(min_o_q), .carry(min_o_c)
  );

  bcd_digit_counter #(.MAX(MIN_T_MAX)) u_min_t (
    .clk(CLK), .rst_n(Reset_time), .load(Set_time),
    .load_val(Time_in[MIN_T +: DIGIT_W]), .inc(min_o_c),
    .q(min_t_q), .carry(min_t_c)
  );

  // Tens carry already covers x9 at tens>=2; the override catches 23..28 and 3x
  assign hour_override = min_t_c &&
                         ((hour_t_q > HOUR_WRAP_T) ||
                          ((hour_t_q == HOUR_WRAP_T) && (hour_o_q >= HOUR_WRAP_O)));
  assign hour_wrap       = hour_override || hour_t_c;
  assign hour_load       = Set_time || hour_wrap;
  assign hour_o_load_val = Set_time ? Time_in[HOUR_O +: DIGIT_W] : DIGIT_RESET;
  assign hour_t_load_val = Set_time ? Time_in[HOUR_T +: DIGIT_W] : DIGIT_RESET;

  bcd_digit_counter #(.MAX(HOUR_O_MAX)) u_hour_o (
    .clk(CLK), .rst_n(Reset_time), .load(hour_load),
    .load_val(hour_o_load_val), .inc(min_t_c),
    .q(hour_o_q), .carry(hour_o_c)
  );

  bcd_digit_counter #(.MAX(HOUR_T_MAX)) u_hour_t (
    .clk(CLK), .rst_n(Reset_time), .load(hour_load),
    .load_val(hour_t_load_val), .inc(hour_o_c),
    .q(hour_t_q), .carry(hour_t_c)
  );

  assign Time_out[SEC_O  +: DIGIT_W] = sec_o_q;
  assign Time_out[SEC_T  +: DIGIT_W] = sec_t_q;
  assign Time_out[MIN_O  +: DIGIT_W] = min_o_q;
  assign Time_out[MIN_T  +: DIGIT_W] = min_t_q;
  assign Time_out[HOUR_O +: DIGIT_W] = hour_o_q;
  assign Time_out[HOUR_T +: DIGIT_W] = hour_t_q;

endmodule

// File: tb/tb_clock_24_hour_structural.sv
// Randomized and directed bench for the 24-hour BCD clock, checked against a
// time-of-day model that works in whole seconds wherever the time is legal.
module tb_clock_24_hour_structural;

  logic        CLK;
  logic        Reset_time;
  logic        Set_time;
  logic [23:0] Time_in;
  logic [23:0] Time_out;

  int          checks_cnt;
  int          fail_cnt;
  logic [23:0] exp_time;

  clock_24_hour_structural dut (
    .CLK(CLK),
    .Reset_time(Reset_time),
    .Set_time(Set_time),
    .Time_in(Time_in),
    .Time_out(Time_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    logic [3:0] ht, ho, mt, mo, st, so;
    ht = 4'(h / 10); ho = 4'(h % 10);
    mt = 4'(m / 10); mo = 4'(m % 10);
    st = 4'(s / 10); so = 4'(s % 10);
    return {ht, ho, mt, mo, st, so};
  endfunction

  function automatic bit legal_time(input logic [23:0] t);
    int d[6];
    for (int i = 0; i < 6; i++) d[i] = int'(t[i*4 +: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
    if (d[1] > 5 || d[3] > 5) return 1'b0;
    return (d[5] * 10 + d[4]) <= 23;
  endfunction

  // Legal times: add one second modulo a day. Otherwise apply the digit wrap rules.
  function automatic logic [23:0] model_next(input logic [23:0] t);
    int d[6];
    int total;
    bit c;
    for (int i = 0; i < 6; i++) d[i] = int'(t[i*4 +: 4]);
    if (legal_time(t)) begin
      total = ((d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0] + 1) % 86400;
      return to_bcd(total / 3600, (total / 60) % 60, total % 60);
    end
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (d[i] >= ((i % 2 == 0) ? 9 : 5)) d[i] = 0;
        else begin d[i] = d[i] + 1; c = 1'b0; end
      end
    end
    if (c) begin
      if (d[5] > 2 || (d[5] == 2 && d[4] >= 3)) begin d[5] = 0; d[4] = 0; end
      else if (d[4] >= 9) begin d[4] = 0; d[5] = d[5] + 1; end
      else d[4] = d[4] + 1;
    end
    return {4'(d[5]), 4'(d[4]), 4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
  endfunction

  task automatic step(input string tag, input logic rst_n, input logic set,
                      input logic [23:0] tin, input bit verbose);
    Reset_time = rst_n;
    Set_time   = set;
    Time_in    = tin;
    @(posedge CLK);
    #1;
    if (!rst_n)   exp_time = 24'h000000;
    else if (set) exp_time = tin;
    else          exp_time = model_next(exp_time);
    check(tag, Time_out, exp_time);
    if (verbose)
      $display("%-10s rst_n=%0b set=%0b tin=%06h out=%06h exp=%06h",
               tag, rst_n, set, tin, Time_out, exp_time);
  endtask

  initial begin
    logic [23:0] rnd_time;
    checks_cnt = 0;
    fail_cnt   = 0;
    exp_time   = 24'h000000;
    Reset_time = 1'b1;
    Set_time   = 1'b0;
    Time_in    = 24'h000000;
    #2;

    // Reset and reset-over-load priority
    step("rst_first", 1'b0, 1'b0, 24'h000000, 1'b1);
    step("load_arb",  1'b1, 1'b1, 24'h134217, 1'b1);
    step("rst_arb",   1'b0, 1'b0, 24'h000000, 1'b1);
    step("rst_prio",  1'b0, 1'b1, 24'h235955, 1'b1);
    step("rst_prio2", 1'b0, 1'b1, 24'h235955, 1'b1);

    // Midnight rollover
    step("load_2359", 1'b1, 1'b1, 24'h235955, 1'b1);
    for (int i = 0; i < 5; i++) step("midnight", 1'b1, 1'b0, 24'h000000, 1'b1);
    check("midnight_end", Time_out, 24'h000000);

    // Hour carries, minute and second boundaries, out-of-range digit
    step("load_09",   1'b1, 1'b1, 24'h095959, 1'b1);
    step("hr_09_10",  1'b1, 1'b0, 24'h000000, 1'b1);
    step("load_19",   1'b1, 1'b1, 24'h195959, 1'b1);
    step("hr_19_20",  1'b1, 1'b0, 24'h000000, 1'b1);
    step("load_s09",  1'b1, 1'b1, 24'h120009, 1'b1);
    step("sec_09_10", 1'b1, 1'b0, 24'h000000, 1'b1);
    step("load_s59",  1'b1, 1'b1, 24'h120059, 1'b1);
    step("min_carry", 1'b1, 1'b0, 24'h000000, 1'b1);
    step("load_bad",  1'b1, 1'b1, 24'h12345C, 1'b1);
    check("bad_digit", Time_out, 24'h12345C);
    step("bad_wrap",  1'b1, 1'b0, 24'h000000, 1'b1);
    check("bad_wrap_c", Time_out, 24'h123500);
    step("load_h25",  1'b1, 1'b1, 24'h255959, 1'b1);
    step("h25_wrap",  1'b1, 1'b0, 24'h000000, 1'b1);
    step("load_h30",  1'b1, 1'b1, 24'h305959, 1'b1);
    step("h30_wrap",  1'b1, 1'b0, 24'h000000, 1'b1);

    // Load in the middle of counting replaces the count without incrementing
    step("load_mid",  1'b1, 1'b1, 24'h120000, 1'b1);
    for (int i = 0; i < 7; i++) step("run_mid", 1'b1, 1'b0, 24'h000000, 1'b1);
    step("set_mid",   1'b1, 1'b1, 24'h081530, 1'b1);
    step("after_set", 1'b1, 1'b0, 24'h000000, 1'b1);

    // Randomized mix of reset, load (legal or arbitrary) and counting
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) != 0)
        rnd_time = to_bcd(int'($urandom_range(23)), int'($urandom_range(59)), int'($urandom_range(59)));
      else
        rnd_time = 24'($urandom);
      if ($urandom_range(19) == 0)     step("rand_rst",  1'b0, 1'($urandom_range(1)), rnd_time, 1'b1);
      else if ($urandom_range(7) == 0) step("rand_set",  1'b1, 1'b1, rnd_time, 1'b1);
      else                             step("rand_inc",  1'b1, 1'b0, rnd_time, 1'b1);
    end

    // Full day from reset; every edge must hold a legal time
    step("day_rst", 1'b0, 1'b0, 24'h000000, 1'b1);
    for (int i = 0; i < 86400; i++) begin
      step("day_run", 1'b1, 1'b0, 24'h000000, 1'b0);
      check("day_legal", {23'd0, legal_time(Time_out)}, 24'd1);
    end
    check("day_end", Time_out, 24'h000000);
    $display("day_run    86400 edges completed out=%06h", Time_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
